video_planes: RTL

Parametrised bit-plane video serialiser for the Lynx display path, a generalisation of the fixed three-plane shifter. A free-running slot counter sequences one byte fetch per colour plane from video RAM. It outputs the bank-select code for each fetch and latches each plane byte on its slot. All planes are then transferred together into shift registers and serialised one pixel per `ce`, with these additions:
- per-plane enable masking;
- a border colour outside the active display;
- a registered valid flag;
- full synchronous reset of all state.

---
 rtl/video_pkg.sv | 35 +++
 rtl/video_plane_shifter.sv | 57 +++++
 rtl/video_planes.sv | 79 +++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared slot constants and helpers for the bit-plane video serialiser.
// Holds fetch/load slot positions, bank selection and a config check.
package video_pkg;

    // Slot at which plane k's RAM byte is latched.
    function automatic int load_slot(input int k);
        return 2 * k + 1;
    endfunction

    // Slot at which all planes transfer into the shifters.
    function automatic int out_slot(input int width);
        return width - 1;
    endfunction

    // Every plane fetch must finish before the output load slot.
    function automatic bit cfg_ok(input int planes, input int width);
        return (2 * planes + 1 <= width) && (width >= 4)
            && ((width & (width - 1)) == 0);
    endfunction

    // The last plane's pair can be steered to the alternate bank.
    function automatic int bank_sel(
        input int slot,
        input bit altg,
        input int planes
    );
        int p;
        p = slot >> 1;
        if (p == planes - 1) begin
            return altg ? planes - 1 : planes;
        end
        return p;
    endfunction

endpackage

// File: rtl/video_plane_shifter.sv
// One colour plane: fetch latch, pixel shift register, depth expansion.
// Ports: clock/reset, ce/de, slot, mask, border, pvalid, di -> rgb field.
module video_plane_shifter
    import video_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CDEPTH = 3,
    parameter int SW     = 3,
    parameter int K      = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              de,
    input  logic [SW-1:0]     slot,
    input  logic              mask,
    input  logic              border,
    input  logic              pvalid,
    input  logic [WIDTH-1:0]  di,
    output logic [CDEPTH-1:0] rgb
);

    localparam logic [SW-1:0] LSLOT = SW'(load_slot(K));
    localparam logic [SW-1:0] OSLOT = SW'(out_slot(WIDTH));

    logic [WIDTH-1:0] lat_q, lat_d;
    logic [WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        lat_d = lat_q;
        sh_d  = sh_q;
        if (ce) begin
            if (de && slot == LSLOT) begin
                lat_d = di;
            end
            // Without de at the load slot the old byte keeps draining.
            if (de && slot == OSLOT) begin
                sh_d = lat_q & {WIDTH{mask}};
            end else begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_q <= '0;
            sh_q  <= '0;
        end else begin
            lat_q <= lat_d;
            sh_q  <= sh_d;
        end
    end

    assign rgb = {CDEPTH{pvalid ? sh_q[WIDTH-1] : border}};

endmodule

// File: rtl/video_planes.sv
// Bit-plane video serialiser: slot sequencer, bank select, pixel valid.
// Ports: clock, reset, ce, de, altg, pmask, border, di -> rgb, b, pvalid.
module video_planes
    import video_pkg::*;
#(
    parameter int PLANES = 3,
    parameter int WIDTH  = 8,
    parameter int CDEPTH = 3
) (
    input  logic                       reset,
    input  logic                       clock,
    input  logic                       ce,
    input  logic                       de,
    input  logic                       altg,
    input  logic [PLANES-1:0]          pmask,
    input  logic [PLANES-1:0]          border,
    input  logic [WIDTH-1:0]           di,
    output logic [PLANES*CDEPTH-1:0]   rgb,
    output logic [$clog2(WIDTH)-2:0]   b,
    output logic                       pvalid
);

    localparam int SW = $clog2(WIDTH);
    localparam int BW = SW - 1;
    localparam logic [SW-1:0] OSLOT = SW'(out_slot(WIDTH));

    if (!cfg_ok(PLANES, WIDTH)) begin : g_bad_cfg
        $error("video_planes: PLANES/WIDTH combination unsupported");
    end

    logic [SW-1:0] slot_q, slot_d;
    logic          pvalid_q, pvalid_d;

    always_comb begin
        slot_d   = slot_q;
        pvalid_d = pvalid_q;
        if (ce) begin
            // WIDTH is a power of two, so the wrap is natural.
            slot_d = slot_q + SW'(1);
            if (slot_q == OSLOT) begin
                pvalid_d = de;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_q   <= '0;
            pvalid_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign pvalid = pvalid_q;
    assign b      = BW'(bank_sel(int'(slot_q), altg, PLANES));

    for (genvar k = 0; k < PLANES; k++) begin : g_plane
        video_plane_shifter #(
            .WIDTH  (WIDTH),
            .CDEPTH (CDEPTH),
            .SW     (SW),
            .K      (k)
        ) u_shifter (
            .clock  (clock),
            .reset  (reset),
            .ce     (ce),
            .de     (de),
            .slot   (slot_q),
            .mask   (pmask[k]),
            .border (border[k]),
            .pvalid (pvalid_q),
            .di     (di),
            .rgb    (rgb[k*CDEPTH +: CDEPTH])
        );
    end

endmodule
